// File: rtl/montgomery_pkg.sv
// Shared constants and width helpers for the Montgomery reduction pipeline.
// Payload structs depend on module parameters, so they are declared in the top from these widths.
package montgomery_pkg;

    localparam int Q_NH      = 12289;
    localparam int R_BITS_NH = 18;
    localparam int QINV_NH   = 12287;

    typedef enum logic [1:0] {
        WSEL_P,
        WSEL_T,
        WSEL_R
    } width_sel_e;

    // p = m*Q, t = a + p (one carry bit), r = t >> R_BITS
    function automatic int mont_width(input width_sel_e sel, input int q, input int rBits, input int inW);
        int pW;
        int tW;
        pW = rBits + $clog2(q);
        tW = ((inW > pW) ? inW : pW) + 1;
        case (sel)
            WSEL_P:  return pW;
            WSEL_T:  return tW;
            default: return tW - rBits;
        endcase
    endfunction

endpackage

// File: rtl/mont_stage_reg.sv
// One elastic pipeline slot: a valid bit plus payload that loads whenever the slot is empty
// or is being drained in the same cycle, so bubbles collapse.
module mont_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_down_ready,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_down_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // Payload is deliberately not reset; it is only meaningful under r_valid.
    always_ff @(posedge clk) begin
        if (o_ready && i_valid) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Four-stage elastic Montgomery reducer: out = in * 2^-R_BITS mod Q, optionally canonicalised,
// with a per-beat tag and an out-of-range flag.
module montgomery_reduce_pipe
    import montgomery_pkg::*;
#(
    parameter int Q      = Q_NH,
    parameter int R_BITS = R_BITS_NH,
    parameter int QINV   = QINV_NH,
    parameter int IN_W   = 32,
    parameter int OUT_W  = 16,
    parameter int TAG_W  = 8,
    parameter int CANON  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int P_W = mont_width(WSEL_P, Q, R_BITS, IN_W);
    localparam int T_W = mont_width(WSEL_T, Q, R_BITS, IN_W);
    localparam int R_W = mont_width(WSEL_R, Q, R_BITS, IN_W);

    localparam logic [T_W-1:0] QR_LIMIT = T_W'(Q) << R_BITS;

    typedef struct packed {
        logic [IN_W-1:0]   a;
        logic [TAG_W-1:0]  tag;
        logic              err;
        logic [R_BITS-1:0] m;
    } s1_t;

    typedef struct packed {
        logic [IN_W-1:0]  a;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [P_W-1:0]   p;
    } s2_t;

    // The low R_BITS of t are always zero, so only the quotient part is kept.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [R_W-1:0]   tHi;
    } s3_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [OUT_W-1:0] data;
    } s4_t;

    s1_t w_s1Next, w_s1;
    s2_t w_s2Next, w_s2;
    s3_t w_s3Next, w_s3;
    s4_t w_s4Next, w_s4;

    logic           w_v1, w_v2, w_v3, w_v4;
    logic           w_s2Ready, w_s3Ready, w_s4Ready;
    logic [R_W-1:0] w_r;

    always_comb begin
        w_s1Next.a   = in_data;
        w_s1Next.tag = in_tag;
        w_s1Next.err = (T_W'(in_data) >= QR_LIMIT);
        w_s1Next.m   = R_BITS'(in_data) * R_BITS'(QINV);
    end

    always_comb begin
        w_s2Next.a   = w_s1.a;
        w_s2Next.tag = w_s1.tag;
        w_s2Next.err = w_s1.err;
        w_s2Next.p   = P_W'(w_s1.m) * P_W'(Q);
    end

    always_comb begin
        w_s3Next.tag = w_s2.tag;
        w_s3Next.err = w_s2.err;
        w_s3Next.tHi = R_W'((T_W'(w_s2.a) + T_W'(w_s2.p)) >> R_BITS);
    end

    always_comb begin
        w_r = w_s3.tHi;
        if ((CANON != 0) && (w_s3.tHi >= R_W'(Q))) begin
            w_r = w_s3.tHi - R_W'(Q);
        end
        w_s4Next.tag  = w_s3.tag;
        w_s4Next.err  = w_s3.err;
        w_s4Next.data = OUT_W'(w_r);
    end

    mont_stage_reg #(.W($bits(s1_t))) u_s1 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (in_valid),
        .i_data       (w_s1Next),
        .i_down_ready (w_s2Ready),
        .o_ready      (in_ready),
        .o_valid      (w_v1),
        .o_data       (w_s1)
    );

    mont_stage_reg #(.W($bits(s2_t))) u_s2 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (w_v1),
        .i_data       (w_s2Next),
        .i_down_ready (w_s3Ready),
        .o_ready      (w_s2Ready),
        .o_valid      (w_v2),
        .o_data       (w_s2)
    );

    mont_stage_reg #(.W($bits(s3_t))) u_s3 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (w_v2),
        .i_data       (w_s3Next),
        .i_down_ready (w_s4Ready),
        .o_ready      (w_s3Ready),
        .o_valid      (w_v3),
        .o_data       (w_s3)
    );

    mont_stage_reg #(.W($bits(s4_t))) u_s4 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (w_v3),
        .i_data       (w_s4Next),
        .i_down_ready (out_ready),
        .o_ready      (w_s4Ready),
        .o_valid      (w_v4),
        .o_data       (w_s4)
    );

    assign out_valid = w_v4;
    assign out_data  = w_s4.data;
    assign out_tag   = w_s4.tag;
    assign out_err   = w_s4.err;
    assign busy      = w_v1 || w_v2 || w_v3 || w_v4;

endmodule
